// File: rtl/code_sender.sv
// Replays a stored digit sequence on the numero/insere strobe interface
// with fixed setup, pulse and gap timing per digit.
module code_sender #(
  parameter int DEPTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int GAP_CYC   = 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          grava,
  input  logic [3:0]    digito_in,
  input  logic          limpa,
  input  logic          envia,
  output logic [3:0]    numero,
  output logic          insere,
  output logic          ocupado,
  output logic          feito,
  output logic [CW-1:0] contagem,
  output logic          cheio
);

  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXC = (SETUP_CYC > PULSE_CYC) ?
                        ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                        ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
  localparam int TW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    num_q, num_d;
  logic          ins_q, ins_d;
  logic          ocu_q, ocu_d;
  logic          fei_q, fei_d;
  logic          chi_q, chi_d;
  logic          wr_en;
  logic [CW-1:0] nxt_idx;
  logic [3:0]    mem [DEPTH];

  assign nxt_idx = idx_q + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      ins_q   <= 1'b0;
      ocu_q   <= 1'b0;
      fei_q   <= 1'b0;
      chi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      ins_q   <= ins_d;
      ocu_q   <= ocu_d;
      fei_q   <= fei_d;
      chi_q   <= chi_d;
    end
  end

  // Storage holds no reset; it is only visible through a send of cnt_q entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q[IW-1:0]] <= digito_in;
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TW'(1);
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    ins_d   = 1'b0;
    ocu_d   = ocu_q;
    fei_d   = 1'b0;
    wr_en   = 1'b0;
    if (limpa) begin
      state_d = IDLE;
      tmr_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
      num_d   = '0;
      ocu_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tmr_d = '0;
          if (envia) begin
            if (cnt_q != '0) begin
              state_d = SETUP;
              idx_d   = '0;
              num_d   = mem[0];
              ocu_d   = 1'b1;
            end else begin
              fei_d = 1'b1;
            end
          end else if (grava && !chi_q) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
        SETUP: begin
          if (tmr_q == TW'(SETUP_CYC - 1)) begin
            state_d = PULSE;
            tmr_d   = '0;
            ins_d   = 1'b1;
          end
        end
        PULSE: begin
          if (tmr_q == TW'(PULSE_CYC - 1)) begin
            state_d = GAP;
            tmr_d   = '0;
          end else begin
            ins_d = 1'b1;
          end
        end
        GAP: begin
          if (tmr_q == TW'(GAP_CYC - 1)) begin
            tmr_d = '0;
            if (idx_q == cnt_q - CW'(1)) begin
              state_d = IDLE;
              idx_d   = '0;
              num_d   = '0;
              ocu_d   = 1'b0;
              fei_d   = 1'b1;
            end else begin
              state_d = SETUP;
              idx_d   = nxt_idx;
              num_d   = mem[nxt_idx[IW-1:0]];
            end
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
    chi_d = (cnt_d == CW'(DEPTH));
  end

  assign numero   = num_q;
  assign insere   = ins_q;
  assign ocupado  = ocu_q;
  assign feito    = fei_q;
  assign contagem = cnt_q;
  assign cheio    = chi_q;

endmodule

// File: tb/tb_code_sender.sv
// Directed bench for code_sender: default-timing instance plus a stretched-timing one.
module tb_code_sender;

  logic       clk, rst_n;
  logic       grava0, limpa0, envia0, grava1, limpa1, envia1;
  logic [3:0] dig0, dig1;
  logic [3:0] num0, num1, cnt0, cnt1;
  logic       ins0, ocu0, fei0, chi0, ins1, ocu1, fei1, chi1;
  int total = 0;
  int bad   = 0;

  code_sender u0 (
    .clk(clk), .reset(rst_n), .grava(grava0), .digito_in(dig0), .limpa(limpa0),
    .envia(envia0), .numero(num0), .insere(ins0), .ocupado(ocu0), .feito(fei0),
    .contagem(cnt0), .cheio(chi0)
  );

  code_sender #(.DEPTH(8), .SETUP_CYC(2), .PULSE_CYC(3), .GAP_CYC(2)) u1 (
    .clk(clk), .reset(rst_n), .grava(grava1), .digito_in(dig1), .limpa(limpa1),
    .envia(envia1), .numero(num1), .insere(ins1), .ocupado(ocu1), .feito(fei1),
    .contagem(cnt1), .cheio(chi1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    total++;
    if ({num0, ins0, ocu0, fei0, cnt0, chi0} !== 12'h000) begin
      bad++;
      $display("FAIL reset0 num=%0d ins=%b ocu=%b fei=%b cnt=%0d cheio=%b want all 0",
               num0, ins0, ocu0, fei0, cnt0, chi0);
    end
    total++;
    if ({num1, ins1, ocu1, fei1, cnt1, chi1} !== 12'h000) begin
      bad++;
      $display("FAIL reset1 num=%0d ins=%b ocu=%b fei=%b cnt=%0d want all 0",
               num1, ins1, ocu1, fei1, cnt1);
    end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    logic [3:0] seq [7];
    logic [3:0] en;
    logic       ei, eo, ef;
    seq = '{4'd5, 4'd3, 4'd7, 4'd9, 4'd12, 4'd5, 4'd9};
    for (int i = 0; i < 7; i++) begin
      grava0 = 1'b1; dig0 = seq[i]; tick;
    end
    grava0 = 1'b0;
    total++;
    if (cnt0 !== 4'd7 || chi0 !== 1'b0) begin
      bad++;
      $display("FAIL basic_count cnt=%0d cheio=%b want 7/0", cnt0, chi0);
    end
    envia0 = 1'b1; tick; envia0 = 1'b0;
    for (int k = 0; k <= 22; k++) begin
      if (k < 21) begin
        en = seq[k/3]; ei = (k % 3 == 1); eo = 1'b1; ef = 1'b0;
      end else begin
        en = 4'd0; ei = 1'b0; eo = 1'b0; ef = (k == 21);
      end
      total++;
      if (num0 !== en || ins0 !== ei || ocu0 !== eo || fei0 !== ef) begin
        bad++;
        $display("FAIL basic_k%0d num=%0d ins=%b ocu=%b fei=%b want %0d %b %b %b",
                 k, num0, ins0, ocu0, fei0, en, ei, eo, ef);
      end
      tick;
    end
  endtask

  task automatic test_full;
    int pulses, fk;
    limpa0 = 1'b1; tick; limpa0 = 1'b0;
    total++;
    if (cnt0 !== 4'd0 || chi0 !== 1'b0) begin
      bad++;
      $display("FAIL full_clear cnt=%0d cheio=%b want 0/0", cnt0, chi0);
    end
    for (int i = 0; i < 9; i++) begin
      grava0 = 1'b1; dig0 = 4'(i + 1); tick;
      if (i == 7) begin
        total++;
        if (cnt0 !== 4'd8 || chi0 !== 1'b1) begin
          bad++;
          $display("FAIL full_8th cnt=%0d cheio=%b want 8/1", cnt0, chi0);
        end
      end
    end
    grava0 = 1'b0;
    total++;
    if (cnt0 !== 4'd8 || chi0 !== 1'b1) begin
      bad++;
      $display("FAIL full_9th cnt=%0d cheio=%b want 8/1", cnt0, chi0);
    end
    envia0 = 1'b1; tick; envia0 = 1'b0;
    pulses = 0; fk = -1;
    for (int k = 0; k <= 26; k++) begin
      if (ins0 === 1'b1) begin
        pulses++;
        total++;
        if (num0 !== 4'(pulses)) begin
          bad++;
          $display("FAIL full_digit%0d num=%0d want %0d", pulses, num0, pulses);
        end
      end
      if (fei0 === 1'b1 && fk < 0) fk = k;
      tick;
    end
    total++;
    if (pulses != 8 || fk != 24) begin
      bad++;
      $display("FAIL full_send pulses=%0d feito_at=%0d want 8/24", pulses, fk);
    end
  endtask

  task automatic test_empty;
    int errs;
    limpa0 = 1'b1; tick; limpa0 = 1'b0;
    envia0 = 1'b1; tick; envia0 = 1'b0;
    total++;
    if (fei0 !== 1'b1 || ins0 !== 1'b0 || ocu0 !== 1'b0) begin
      bad++;
      $display("FAIL empty_feito fei=%b ins=%b ocu=%b want 1/0/0", fei0, ins0, ocu0);
    end
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (fei0 !== 1'b0 || ins0 !== 1'b0 || ocu0 !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL empty_after bad_cycles=%0d want 0", errs);
    end
  endtask

  task automatic test_abort;
    logic [3:0] seq [4];
    int errs;
    seq = '{4'd2, 4'd4, 4'd6, 4'd8};
    limpa0 = 1'b1; tick; limpa0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      grava0 = 1'b1; dig0 = seq[i]; tick;
    end
    grava0 = 1'b0;
    envia0 = 1'b1; tick; envia0 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      total++;
      if (ins0 !== (k % 3 == 1) || num0 !== seq[k/3] || cnt0 !== 4'd4 || ocu0 !== 1'b1) begin
        bad++;
        $display("FAIL abort_k%0d ins=%b num=%0d cnt=%0d ocu=%b want %b %0d 4 1",
                 k, ins0, num0, cnt0, ocu0, (k % 3 == 1), seq[k/3]);
      end
      grava0 = (k == 1); dig0 = 4'd15;
      envia0 = (k == 2);
      limpa0 = (k == 4);
      tick;
    end
    grava0 = 1'b0; envia0 = 1'b0; limpa0 = 1'b0;
    total++;
    if (ins0 !== 1'b0 || num0 !== 4'd0 || ocu0 !== 1'b0 || cnt0 !== 4'd0 || fei0 !== 1'b0) begin
      bad++;
      $display("FAIL abort_now ins=%b num=%0d ocu=%b cnt=%0d fei=%b want 0 0 0 0 0",
               ins0, num0, ocu0, cnt0, fei0);
    end
    errs = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (ins0 !== 1'b0 || fei0 !== 1'b0 || num0 !== 4'd0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL abort_quiet bad_cycles=%0d want 0", errs);
    end
  endtask

  task automatic test_timing;
    logic [3:0] en;
    logic       ei, eo, ef;
    grava1 = 1'b1; dig1 = 4'd10; tick;
    dig1 = 4'd11; tick;
    grava1 = 1'b0;
    envia1 = 1'b1; tick; envia1 = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      en = (k < 14) ? ((k < 7) ? 4'd10 : 4'd11) : 4'd0;
      ei = (k < 14) && (k % 7 >= 2) && (k % 7 <= 4);
      eo = (k < 14);
      ef = (k == 14);
      total++;
      if (num1 !== en || ins1 !== ei || ocu1 !== eo || fei1 !== ef) begin
        bad++;
        $display("FAIL timing_k%0d num=%0d ins=%b ocu=%b fei=%b want %0d %b %b %b",
                 k, num1, ins1, ocu1, fei1, en, ei, eo, ef);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    limpa0 = 1'b1; tick; limpa0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      grava0 = 1'b1; dig0 = 4'(i + 1); tick;
    end
    grava0 = 1'b0;
    envia0 = 1'b1; tick; envia0 = 1'b0;
    tick;
    total++;
    if (ins0 !== 1'b1 || num0 !== 4'd1) begin
      bad++;
      $display("FAIL rstmid_pulse ins=%b num=%0d want 1/1", ins0, num0);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ins0 !== 1'b0 || num0 !== 4'd0 || cnt0 !== 4'd0 || ocu0 !== 1'b0 || fei0 !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async ins=%b num=%0d cnt=%0d ocu=%b fei=%b want 0 0 0 0 0",
               ins0, num0, cnt0, ocu0, fei0);
    end
    @(negedge clk) rst_n = 1'b1;
    tick;
    envia0 = 1'b1; tick; envia0 = 1'b0;
    total++;
    if (fei0 !== 1'b1 || ocu0 !== 1'b0 || ins0 !== 1'b0 || cnt0 !== 4'd0) begin
      bad++;
      $display("FAIL rstmid_empty fei=%b ocu=%b ins=%b cnt=%0d want 1 0 0 0",
               fei0, ocu0, ins0, cnt0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    grava0 = 1'b0; limpa0 = 1'b0; envia0 = 1'b0; dig0 = 4'd0;
    grava1 = 1'b0; limpa1 = 1'b0; envia1 = 1'b0; dig1 = 4'd0;
    test_reset;
    test_basic;
    test_full;
    test_empty;
    test_abort;
    test_timing;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
